// File: rtl/fir_output_capture.sv
// fir_output_capture: captures a programmed run of filter samples with signed min/max tracking, then replays them over valid/ready.
module fir_output_capture #(
  parameter int WL = 32,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [WL-1:0] yin,
  input  logic          yin_valid,
  input  logic          arm,
  input  logic [AW:0]   count,
  input  logic          abort,
  output logic [WL-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  input  logic          rd_ready,
  output logic [WL-1:0] y_min,
  output logic [WL-1:0] y_max,
  output logic          busy,
  output logic          done
);
  typedef enum logic [1:0] {IDLE, CAPTURE, READOUT} state_t;
  state_t state_q, state_d;
  logic [AW:0] len_q, len_d, wr_q, wr_d, rd_q, rd_d, rd_n;
  logic [WL-1:0] min_q, min_d, max_q, max_d, data_q, data_d;
  logic valid_q, valid_d, last_q, last_d, done_q, done_d;
  logic we;
  logic [WL-1:0] mem [DEPTH];
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    wr_d = wr_q;
    rd_d = rd_q;
    min_d = min_q;
    max_d = max_q;
    data_d = data_q;
    valid_d = valid_q;
    last_d = last_q;
    done_d = 1'b0;
    we = state_q == CAPTURE && yin_valid && !abort;
    rd_n = rd_q + (AW+1)'(1);
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d = 1'b0;
    end else if (state_q == IDLE) begin
      wr_d = '0;
      rd_d = '0;
      if (arm) begin
        len_d = (count == '0 || count > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : count;
        state_d = CAPTURE;
      end
    end else if (state_q == CAPTURE) begin
      if (we) begin
        wr_d = wr_q + (AW+1)'(1);
        min_d = (wr_q == '0 || $signed(yin) < $signed(min_q)) ? yin : min_q;
        max_d = (wr_q == '0 || $signed(yin) > $signed(max_q)) ? yin : max_q;
        // sample 0 bypasses the buffer when it is also the final write
        if (wr_d == len_q) begin
          state_d = READOUT;
          valid_d = 1'b1;
          data_d = wr_q == '0 ? yin : mem[0];
          last_d = len_q == (AW+1)'(1);
          rd_d = '0;
        end
      end
    end else if (valid_q && rd_ready) begin
      if (last_q) begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d = 1'b0;
        done_d = 1'b1;
      end else begin
        rd_d = rd_n;
        data_d = mem[rd_n[AW-1:0]];
        last_d = rd_n == len_q - (AW+1)'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      min_q <= '0;
      max_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      min_q <= min_d;
      max_q <= max_d;
      data_q <= data_d;
      valid_q <= valid_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && we) mem[wr_q[AW-1:0]] <= yin;
  end
  assign rd_data = data_q;
  assign rd_valid = valid_q;
  assign rd_last = last_q;
  assign y_min = min_q;
  assign y_max = max_q;
  assign busy = state_q != IDLE;
  assign done = done_q;
endmodule

// File: doc/fir_output_capture.md
# fir_output_capture

Sink-side companion to the FIR `Filter` block. It takes the filter's `yout` stream, captures a programmed number of consecutive valid samples into an internal buffer, and tracks their signed minimum and maximum. It then replays the samples to a downstream reader over a valid/ready handshake. It gives benches and on-chip debug a cycle-exact record of filter response without a simulator dump.

## Interface
Parameters:
- `WL`, 32, sample word length (matches `Filter`), signed two's complement
- `DEPTH`, 16, buffer depth in samples, power of two
- `AW`, 4, log2(DEPTH)

Ports:
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `yin`  in  WL  signed sample from `Filter.yout`
- `yin_valid`  in  1  `yin` is a sample this cycle
- `arm`  in  1  start-capture pulse
- `count`  in  AW+1  samples to capture, latched on `arm`
- `abort`  in  1  synchronous cancel, any state
- `rd_data`  out  WL  replayed sample, signed
- `rd_valid`  out  1  `rd_data` is valid
- `rd_last`  out  1  `rd_data` is the final captured sample
- `rd_ready`  in  1  reader accepts `rd_data`
- `y_min`  out  WL  signed minimum of captured samples
- `y_max`  out  WL  signed maximum of captured samples
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse after the final readout transfer

## Operation
- States: IDLE, CAPTURE, READOUT.
- IDLE:
  - `arm`=1 latches `len`, then enters CAPTURE. `len` = `count`, or DEPTH if `count`=0 or `count`>DEPTH.
  - Write and read pointers clear to 0.
  - `yin_valid` is ignored.
- CAPTURE:
  - Each cycle with `yin_valid`=1, the block writes `yin` to `mem[wr_ptr]` and increments `wr_ptr`.
  - The first captured sample loads both `y_min` and `y_max`.
  - Each later sample updates them by signed compare, min/max in the same edge as the write.
  - On the edge that writes sample number `len`, the block enters READOUT.
  - `arm` is ignored. Gaps in `yin_valid` are allowed; no samples are dropped.
- READOUT:
  - The block presents `mem[rd_ptr]` on `rd_data` with `rd_valid`=1.
  - A transfer occurs when `rd_valid` and `rd_ready` are both 1; `rd_ptr` then increments.
  - `rd_last`=1 exactly when `rd_ptr`=`len`-1.
  - The transfer with `rd_last`=1 returns the block to IDLE and pulses `done` on the next cycle.
  - `yin_valid` and `arm` are ignored.
- `abort`=1: the next state is IDLE from any state, and `done` is not pulsed.
  - `y_min`/`y_max` hold their last values.
  - `abort` takes priority over a simultaneous `arm`, the final write, or the final transfer.
- `y_min`/`y_max` hold after capture until the next `arm` and stay readable in IDLE.
- Arithmetic is signed WL-bit compare only. No saturation or widening.

## Timing
- Reset (`rst_n`=0 at rising edge):
  - State is IDLE.
  - `rd_valid`, `rd_last`, `busy`, `done` = 0.
  - `rd_data`, `y_min`, `y_max` = 0.
  - Pointers = 0.
  - Buffer contents are not reset.
  - Reset mid-capture or mid-readout discards all progress.
- `busy` rises in the cycle after the `arm` edge.
- The first sample can be captured in the cycle after `arm`. A `yin_valid` in the same cycle as `arm` is not captured.
- `rd_valid` first asserts in the cycle after the final capture write, with `rd_data` = sample 0.
- Registered outputs: `rd_data`, `rd_valid`, `rd_last`.
  - While `rd_valid`=1 and `rd_ready`=0, all three hold stable.
  - `rd_valid` never deasserts without a transfer, except on `abort` or reset.
- Throughput: one word per cycle with `rd_ready` held at 1. No bubbles between words.
- After the last transfer, `rd_valid`=0 and `busy`=0 in the next cycle, and `done`=1 for that one cycle.
- A new `arm` is accepted from the cycle `done` is high onward.
- Capture of `len` samples with continuous `yin_valid` takes `len` cycles.

## Test plan
- **Basic capture/readout:**
  - Stimulus: `count`=8, `arm`, then `yin` = 0,-1,-2,3,4,-5,1,0 with continuous `yin_valid`, and `rd_ready`=1.
  - Required: readout is the same 8 values in order, back-to-back, with `rd_last` on the 8th.
  - Required: `y_min`=-5, `y_max`=4, and one `done` pulse.
- **Gapped input and backpressure:**
  - Stimulus: `count`=4, samples 3,4,1,2 with `yin_valid` low every other cycle, and `rd_ready` toggling 1,0,0,1.
  - Required: values are transferred exactly once each, and `rd_data` is stable during stalls.
- **Full and clamped length:**
  - Stimulus: `count`=0, then `count`=31, each with 16 continuous samples 1..16.
  - Required: both runs capture exactly 16 samples.
  - Required: `rd_last` on value 16, `y_min`=1, `y_max`=16.
- **Abort mid-capture:**
  - Stimulus: `count`=8 and 3 samples 6,1,-1, then `abort`=1 together with `arm`=1.
  - Required: IDLE next cycle, `busy`=0, no `done`, and `rd_valid` never asserts.
  - Required: `y_min`=-1, `y_max`=6.
- **Abort in readout and re-arm:**
  - Stimulus: `abort` after 2 of 4 transfers, then re-arm with `count`=2 and samples 7,-1.
  - Required: readout of 7,-1 with `rd_last` on -1, and `y_min`=-1, `y_max`=7.
- **Reset mid-readout:**
  - Stimulus: `rst_n`=0 for 1 cycle while `rd_valid`=1.
  - Required: all outputs are 0 on the next cycle, and `arm` is accepted after reset deasserts.
